// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM image loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_MAGIC = 3'd0,
    S_LOAD  = 3'd1,
    S_PAD   = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } loader_state_t;

  // "ASRM" read little-endian from the first four image bytes.
  localparam logic [31:0] LOADER_MAGIC = 32'h4D525341;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words.
// Bytes above the current index are kept at zero, so the held bytes
// double as the zero-padded word when the stream ends early.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic [1:0]  idx,
  output logic [31:0] word_full,
  output logic [31:0] word_pad,
  output logic        word_valid
);

  logic [23:0] held_q;

  // Store bytes 0..2; the fourth byte completes the word and empties the holder.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      held_q <= '0;
      idx    <= '0;
    end else if (accept) begin
      if (idx == 2'd3) begin
        held_q <= '0;
        idx    <= '0;
      end else begin
        case (idx)
          2'd0:    held_q[7:0]   <= in_data;
          2'd1:    held_q[15:8]  <= in_data;
          default: held_q[23:16] <= in_data;
        endcase
        idx <= idx + 2'd1;
      end
    end
  end

  assign word_full  = {in_data, held_q};
  assign word_pad   = {8'h00, held_q};
  assign word_valid = accept && (idx == 2'd3);

endmodule

// File: rtl/rom_image_loader.sv
// Byte-stream image loader writing little-endian words into a RAM.
// Optional running checksum of written words: define LOADER_CHECKSUM_EN.
//
// state   | meaning
// MAGIC   | collecting bytes 0..3, word 0 must equal MAGIC
// LOAD    | collecting image words, one write per completed word
// PAD     | one cycle: write the zero-padded partial final word
// DONE    | image loaded, input ignored until restart
// ERROR   | image rejected, input ignored until restart
module rom_image_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W = 30,
  parameter int          DEPTH  = 64,
  parameter logic [31:0] MAGIC  = LOADER_MAGIC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              mem_we,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  loader_state_t state, nxt;
  logic          accept;
  logic          wr_req;
  logic [31:0]   wr_data;
  logic          pk_clear;
  logic          mem_full;
  logic          rearm;
  logic [1:0]    pk_idx;
  logic [31:0]   word_full;
  logic [31:0]   word_pad;
  logic          word_valid;

  assign in_ready = (state == S_MAGIC) || (state == S_LOAD);
  assign accept   = in_valid && in_ready;
  assign mem_full = (word_count >= DEPTH_W);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .accept     (accept),
    .in_data    (in_data),
    .idx        (pk_idx),
    .word_full  (word_full),
    .word_pad   (word_pad),
    .word_valid (word_valid)
  );

  // Next-state, write request and re-arm decisions.
  always_comb begin
    nxt     = state;
    wr_req  = 1'b0;
    wr_data = word_full;
    rearm   = 1'b0;
    case (state)
      S_MAGIC: begin
        if (accept) begin
          if (in_last) begin
            nxt = S_ERROR;
          end else if (word_valid) begin
            if (word_full == MAGIC) begin
              wr_req = 1'b1;
              nxt    = S_LOAD;
            end else begin
              nxt = S_ERROR;
            end
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (word_valid) begin
            if (mem_full) begin
              nxt = S_ERROR;
            end else begin
              wr_req = 1'b1;
              nxt    = in_last ? S_DONE : S_LOAD;
            end
          end else if (in_last) begin
            nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        wr_data = word_pad;
        if (mem_full) begin
          nxt = S_ERROR;
        end else begin
          wr_req = 1'b1;
          nxt    = S_DONE;
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) begin
          rearm = 1'b1;
          nxt   = S_MAGIC;
        end
      end
      default: nxt = S_MAGIC;
    endcase
    pk_clear = (nxt == S_DONE) || (nxt == S_ERROR);
  end

  // State, registered write port and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_MAGIC;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      word_count <= '0;
    end else begin
      state  <= nxt;
      mem_we <= wr_req;
      if (wr_req) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_data   <= wr_data;
        word_count <= word_count + 1'b1;
      end else if (rearm) begin
        mem_addr   <= '0;
        word_count <= '0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  // Running sum of every word written, visible alongside mem_we.
  always_ff @(posedge clk) begin
    if (reset || rearm) begin
      checksum_q <= '0;
    end else if (wr_req) begin
      checksum_q <= checksum_q + wr_data;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
Writer-side counterpart of the simulation ROMs. Consumes a byte stream carrying a Reflet program image and writes it as little-endian 32-bit words into a synchronous word-addressed RAM, starting at word 0. Validates the image magic word 0x4D525341 ("ASRM") and reports done, error and word count. Sits between a byte source (UART receiver or testbench) and the RAM that replaces a ROM in loadable builds.

Parameters:
ADDR_W, 30, width of the word address, matching the 30-bit ROM address bus.
DEPTH, 64, maximum number of words the image may occupy; legal addresses are 0..DEPTH-1.
MAGIC, 32'h4D525341, required value of word 0.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_data  input  8  image byte.
in_valid  input  1  in_data is valid this cycle.
in_last  input  1  qualifies in_valid; this byte is the final byte of the image.
in_ready  output  1  loader accepts a byte this cycle.
restart  input  1  one-cycle pulse; from DONE or ERROR, re-arm for a new image.
mem_addr  output  ADDR_W  word write address.
mem_data  output  32  word write data.
mem_we  output  1  one-cycle write strobe; the RAM accepts every cycle, with no backpressure.
done  output  1  image loaded successfully (level).
error  output  1  image rejected (level).
word_count  output  ADDR_W+1  number of words written so far.
checksum  output  32  running image checksum (see Optional Feature).

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset: state=MAGIC, byte index=0, mem_addr=0, mem_data=0, mem_we=0, done=0, error=0, word_count=0, checksum=0. Reset mid-load discards the partial word and the progress; RAM contents are left untouched.
- A byte is accepted when in_valid && in_ready. in_ready=1 only in MAGIC and LOAD, and is 0 during the PAD cycle.
- Byte assembly: the byte with index k (0..3) goes into bits [8k+7:8k], so the stream 41 53 52 4D yields 0x4D525341.
- States:
  - MAGIC: accumulates bytes 0..3.
    - On the 4th accepted byte: if the assembled word equals MAGIC, write it to address 0 and go to LOAD. Otherwise go to ERROR with no write.
    - in_last on any byte in MAGIC goes to ERROR, because the image is too short. This includes a 4th byte with in_last; no write occurs.
  - LOAD: on each 4th accepted byte, write the assembled word at the next address.
    - in_last on byte index 3: write that word, then go to DONE.
    - in_last on byte index 0..2: go to PAD.
  - PAD: zero-fill the unreceived upper bytes, write the word, then go to DONE. PAD lasts exactly one cycle.
  - DONE: done=1. Further input is ignored because in_ready=0.
  - ERROR: error=1. Further input is ignored because in_ready=0.
  - From DONE or ERROR, restart returns the loader to MAGIC and clears done, error, word_count, checksum and the address. restart is ignored in MAGIC, LOAD and PAD.
- Write timing: mem_we, mem_addr and mem_data are registered and asserted exactly one cycle after the cycle that accepted the completing byte (or one cycle after PAD is entered). word_count increments in the same cycle mem_we is high.
- Overflow: if a word completes, or PAD is entered, while DEPTH words have already been written, go to ERROR with no write. word_count saturates at DEPTH.
- done and error are never both 1.

Optional Feature:
LOADER_CHECKSUM_EN.
- Defined: checksum is the modulo-2^32 sum of every word written, including the magic word and any padded word. It updates in the cycle mem_we is high.
- Undefined: checksum is tied to 0 and no adder is synthesized.

Decomposition:
- Shared package loader_pkg holds the state enum (MAGIC, LOAD, PAD, DONE, ERROR) and the default magic constant LOADER_MAGIC=32'h4D525341.
- One natural sub-module: byte_packer. It takes bytes plus last and produces a 32-bit little-endian word, a word_valid pulse and zero-padding. The top-level FSM owns the address, the checks and the status outputs.

Test Plan:
- Stream 41 53 52 4D 00 10 00 00 with in_last on the final byte -> writes (0, 0x4D525341) then (1, 0x00001000); done=1; word_count=2; with LOADER_CHECKSUM_EN, checksum=0x4D526341.
- Stream 41 53 52 4E plus further bytes -> error=1, no mem_we ever, in_ready=0 afterwards.
- Valid magic, then bytes 04 03 with in_last on 03 -> PAD write (1, 0x00000304); done=1; word_count=2.
- DEPTH=2, magic plus 8 more bytes -> second word written at address 1, third word gives error=1 with no write at address 2; word_count=2.
- Assert reset after 6 accepted bytes, then send a complete 2-word image -> first write lands at address 0; word_count=2; no stale bytes in the data.
- From DONE, pulse restart, then send magic with in_last on byte 2 -> error=1; word_count=0; no writes.
